// File: rtl/scene_restore_ctrl.sv
// Frame sequencer for the scene restoration datapath: airlight latch, pixel gating,
// t_inv alignment delay and valid/sof/eol/eof sideband generation.
module scene_restore_ctrl #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int LAT    = 5,
    parameter int TINV_W = 12
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_a_valid,
    input  logic [7:0]        i_ar,
    input  logic [7:0]        i_ag,
    input  logic [7:0]        i_ab,
    input  logic              i_s_valid,
    output logic              o_s_ready,
    input  logic [7:0]        i_hr,
    input  logic [7:0]        i_hg,
    input  logic [7:0]        i_hb,
    input  logic [TINV_W-1:0] i_t_inv,
    output logic [7:0]        o_dp_hr,
    output logic [7:0]        o_dp_hg,
    output logic [7:0]        o_dp_hb,
    output logic [7:0]        o_dp_ar,
    output logic [7:0]        o_dp_ag,
    output logic [7:0]        o_dp_ab,
    output logic [TINV_W-1:0] o_dp_tinv,
    output logic              o_m_valid,
    output logic              o_m_sof,
    output logic              o_m_eol,
    output logic              o_m_eof,
    output logic              o_busy,
    output logic              o_frame_done
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H + 1);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic              r_sReady;
    logic              r_frameDone;
    logic [7:0]        r_ar;
    logic [7:0]        r_ag;
    logic [7:0]        r_ab;
    logic [XW-1:0]     r_xCnt;
    logic [YW-1:0]     r_yCnt;
    logic [3:0]        r_sb   [LAT-1];
    logic [TINV_W-1:0] r_tinv [LAT-1];

    logic w_accept;
    logic w_sof;
    logic w_eol;
    logic w_eof;
    logic w_latchAir;
    logic w_done;

    assign w_accept = i_s_valid & r_sReady;
    assign w_sof    = (r_xCnt == '0) && (r_yCnt == '0);
    assign w_eol    = (r_xCnt == X_LAST);
    assign w_eof    = w_eol && (r_yCnt == Y_LAST);

    always_comb begin
        w_nextState = r_state;
        w_latchAir  = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE:  if (i_start) w_nextState = ST_LOAD;
            ST_LOAD: begin
                if (i_a_valid) begin
                    w_nextState = ST_RUN;
                    w_latchAir  = 1'b1;
                end
            end
            ST_RUN:   if (w_accept && w_eof) w_nextState = ST_DRAIN;
            // The eof pixel is the last one accepted, so the pipe is empty once it leaves.
            ST_DRAIN: begin
                if (o_m_valid && o_m_eof) begin
                    w_nextState = ST_IDLE;
                    w_done      = 1'b1;
                end
            end
            default:  w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_sReady    <= 1'b0;
            r_frameDone <= 1'b0;
        end else begin
            r_state     <= w_nextState;
            r_sReady    <= (w_nextState == ST_RUN);
            r_frameDone <= w_done;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ar <= '0;
            r_ag <= '0;
            r_ab <= '0;
        end else if (w_latchAir) begin
            r_ar <= i_ar;
            r_ag <= i_ag;
            r_ab <= i_ab;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || w_latchAir) begin
            r_xCnt <= '0;
            r_yCnt <= '0;
        end else if (w_accept) begin
            if (w_eol) begin
                r_xCnt <= '0;
                r_yCnt <= r_yCnt + YW'(1);
            end else begin
                r_xCnt <= r_xCnt + XW'(1);
            end
        end
    end

    // Sideband and t_inv share the same LAT-1 stage delay so they meet the pixel together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < LAT - 1; i++) begin
                r_sb[i]   <= '0;
                r_tinv[i] <= '0;
            end
        end else begin
            r_sb[0]   <= {w_accept, w_accept & w_sof, w_accept & w_eol, w_accept & w_eof};
            r_tinv[0] <= w_accept ? i_t_inv : '0;
            for (int i = 1; i < LAT - 1; i++) begin
                r_sb[i]   <= r_sb[i-1];
                r_tinv[i] <= r_tinv[i-1];
            end
        end
    end

    assign o_s_ready    = r_sReady;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_frame_done = r_frameDone;
    assign o_dp_hr      = w_accept ? i_hr : '0;
    assign o_dp_hg      = w_accept ? i_hg : '0;
    assign o_dp_hb      = w_accept ? i_hb : '0;
    assign o_dp_ar      = r_ar;
    assign o_dp_ag      = r_ag;
    assign o_dp_ab      = r_ab;
    assign o_dp_tinv    = r_tinv[LAT-2];
    assign o_m_valid    = r_sb[LAT-2][3];
    assign o_m_sof      = r_sb[LAT-2][2];
    assign o_m_eol      = r_sb[LAT-2][1];
    assign o_m_eof      = r_sb[LAT-2][0];

endmodule

// File: tb/tb_scene_restore_ctrl.sv
// Directed, table-driven bench for scene_restore_ctrl with a 4x2 frame and LAT=5.
// Each table row is one clock cycle of inputs plus the outputs expected in that cycle.
module tb_scene_restore_ctrl;

    localparam int IMG_W  = 4;
    localparam int IMG_H  = 2;
    localparam int LAT    = 5;
    localparam int TINV_W = 12;

    localparam logic [3:0] SB_NONE = 4'b0000;
    localparam logic [3:0] SB_SOF  = 4'b1100;
    localparam logic [3:0] SB_MID  = 4'b1000;
    localparam logic [3:0] SB_EOL  = 4'b1010;
    localparam logic [3:0] SB_EOF  = 4'b1011;

    logic              clk = 1'b0;
    logic              rst;
    logic              start, aValid, sValid, sReady;
    logic [7:0]        ar, ag, ab, hr, hg, hb;
    logic [TINV_W-1:0] tInv, dpTinv;
    logic [7:0]        dpHr, dpHg, dpHb, dpAr, dpAg, dpAb;
    logic              mValid, mSof, mEol, mEof, busy, frameDone;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic        start;
        logic        aValid;
        logic [7:0]  ar;
        logic        sValid;
        logic [7:0]  hr;
        logic [11:0] tinv;
        logic        expReady;
        logic        expBusy;
        logic [3:0]  expSide;
        logic        expDone;
        logic [11:0] expTinv;
        logic [7:0]  expAr;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    scene_restore_ctrl #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .LAT   (LAT),
        .TINV_W(TINV_W)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .i_a_valid   (aValid),
        .i_ar        (ar),
        .i_ag        (ag),
        .i_ab        (ab),
        .i_s_valid   (sValid),
        .o_s_ready   (sReady),
        .i_hr        (hr),
        .i_hg        (hg),
        .i_hb        (hb),
        .i_t_inv     (tInv),
        .o_dp_hr     (dpHr),
        .o_dp_hg     (dpHg),
        .o_dp_hb     (dpHb),
        .o_dp_ar     (dpAr),
        .o_dp_ag     (dpAg),
        .o_dp_ab     (dpAb),
        .o_dp_tinv   (dpTinv),
        .o_m_valid   (mValid),
        .o_m_sof     (mSof),
        .o_m_eol     (mEol),
        .o_m_eof     (mEof),
        .o_busy      (busy),
        .o_frame_done(frameDone)
    );

    // One comparison: counts it, and reports a FAIL line when actual and expected differ.
    task automatic checkOutput(input string name, input int tag, input logic [31:0] act,
                               input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, tag, act, exp);
        end
    endtask

    task automatic addRow(input logic st, input logic av, input logic [7:0] a,
                          input logic sv, input logic [7:0] h, input logic [11:0] ti,
                          input logic rdy, input logic bsy, input logic [3:0] side,
                          input logic dn, input logic [11:0] eti, input logic [7:0] ear);
        vec_t v;
        v.start = st;  v.aValid = av;  v.ar = a;
        v.sValid = sv; v.hr = h;       v.tinv = ti;
        v.expReady = rdy; v.expBusy = bsy; v.expSide = side;
        v.expDone = dn;   v.expTinv = eti; v.expAr = ear;
        vecs.push_back(v);
    endtask

    // Secondary channels are offset from the primary so a crossed wire shows up.
    task automatic applyStimulus(input vec_t v);
        start  = v.start;
        aValid = v.aValid;
        ar     = v.ar;
        ag     = v.ar + 8'd1;
        ab     = v.ar + 8'd2;
        sValid = v.sValid;
        hr     = v.hr;
        hg     = v.hr + 8'd1;
        hb     = v.hr + 8'd2;
        tInv   = v.tinv;
    endtask

    task automatic checkRow(input int tag, input vec_t v);
        logic [7:0] eHr;
        logic [7:0] eAb;
        eHr = (v.sValid && v.expReady) ? v.hr : 8'd0;
        eAb = (v.expAr == 8'd0) ? 8'd0 : v.expAr + 8'd2;
        checkOutput("s_ready",    tag, 32'(sReady),    32'(v.expReady));
        checkOutput("busy",       tag, 32'(busy),      32'(v.expBusy));
        checkOutput("sideband",   tag, 32'({mValid, mSof, mEol, mEof}), 32'(v.expSide));
        checkOutput("frame_done", tag, 32'(frameDone), 32'(v.expDone));
        checkOutput("dp_tinv",    tag, 32'(dpTinv),    32'(v.expTinv));
        checkOutput("dp_ar",      tag, 32'(dpAr),      32'(v.expAr));
        checkOutput("dp_ab",      tag, 32'(dpAb),      32'(eAb));
        checkOutput("dp_hr",      tag, 32'(dpHr),      32'(eHr));
        checkOutput("dp_hg",      tag, 32'(dpHg),      32'((eHr == 8'd0) ? 8'd0 : eHr + 8'd1));
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Frame 1: airlight 200, 8 back-to-back pixels, start and a_valid poked mid-frame.
        addRow(1, 0, 0,   0, 0, 0,    0, 0, SB_NONE, 0, 0, 0);
        addRow(0, 1, 200, 0, 0, 0,    0, 1, SB_NONE, 0, 0, 0);
        for (int k = 0; k < 8; k++) begin
            logic [3:0] side;
            side = (k == 4) ? SB_SOF : (k == 7) ? SB_EOL : (k > 4) ? SB_MID : SB_NONE;
            addRow(k == 2, k == 3, (k == 3) ? 8'd50 : 8'd0, 1, 8'(10 + k), 12'(12'h100 + k),
                   1, 1, side, 0, (k >= 4) ? 12'(12'h100 + k - 4) : 12'h000, 200);
        end
        // DRAIN: offered pixel is refused, start ignored.
        for (int j = 0; j < 4; j++) begin
            addRow(j == 1, 0, 0, j == 0, 99, (j == 0) ? 12'hABC : 12'h000,
                   0, 1, (j == 3) ? SB_EOF : SB_MID, 0, 12'(12'h104 + j), 200);
        end
        addRow(0, 0, 0,   0, 0, 0,    0, 0, SB_NONE, 1, 0, 200);
        // Frame 2: airlight 77, bubble after pixel 0, 10-cycle source stall after pixel 3.
        addRow(1, 0, 0,   0, 0, 0,       0, 0, SB_NONE, 0, 0, 200);
        addRow(0, 1, 77,  0, 0, 0,       0, 1, SB_NONE, 0, 0, 200);
        addRow(0, 0, 0,   1, 30, 12'h100, 1, 1, SB_NONE, 0, 0, 77);
        addRow(0, 0, 0,   0, 0, 0,       1, 1, SB_NONE, 0, 0, 77);
        addRow(0, 0, 0,   1, 31, 12'h080, 1, 1, SB_NONE, 0, 0, 77);
        addRow(0, 0, 0,   1, 32, 12'h011, 1, 1, SB_NONE, 0, 0, 77);
        addRow(0, 0, 0,   1, 33, 12'h022, 1, 1, SB_SOF,  0, 12'h100, 77);
        for (int i = 0; i < 10; i++) begin
            logic [3:0]  side;
            logic [11:0] et;
            side = (i == 1 || i == 2) ? SB_MID : (i == 3) ? SB_EOL : SB_NONE;
            et   = (i == 1) ? 12'h080 : (i == 2) ? 12'h011 : (i == 3) ? 12'h022 : 12'h000;
            addRow(0, 0, 0, 0, 0, 0, 1, 1, side, 0, et, 77);
        end
        for (int k = 0; k < 4; k++) begin
            addRow(0, 0, 0, 1, 8'(34 + k), 12'(12'h033 + 12'h011 * k), 1, 1, SB_NONE, 0, 0, 77);
        end
        for (int k = 0; k < 4; k++) begin
            addRow(0, 0, 0, 0, 0, 0, 0, 1, (k == 3) ? SB_EOF : SB_MID, 0,
                   12'(12'h033 + 12'h011 * k), 77);
        end
        addRow(0, 0, 0,   0, 0, 0,    0, 0, SB_NONE, 1, 0, 77);
        addRow(0, 0, 0,   0, 0, 0,    0, 0, SB_NONE, 0, 0, 77);

        rst = 1'b1;
        applyStimulus(vecs[$]);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset busy",     0, 32'(busy),   32'd0);
        checkOutput("reset s_ready",  0, 32'(sReady), 32'd0);
        checkOutput("reset m_valid",  0, 32'(mValid), 32'd0);
        checkOutput("reset dp_ar",    0, 32'(dpAr),   32'd0);
        checkOutput("reset dp_tinv",  0, 32'(dpTinv), 32'd0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            #3;
            checkRow(i, vecs[i]);
            nextCycle();
        end

        // Reset mid-RUN with two pixels still in flight.
        start = 1'b1;
        nextCycle();
        start = 1'b0; aValid = 1'b1; ar = 8'd90;
        nextCycle();
        aValid = 1'b0; sValid = 1'b1; hr = 8'd40; tInv = 12'h111;
        #3;
        checkOutput("mid-run s_ready", 100, 32'(sReady), 32'd1);
        checkOutput("mid-run dp_ar",   100, 32'(dpAr),   32'd90);
        nextCycle();
        hr = 8'd41;
        nextCycle();
        sValid = 1'b0;
        rst = 1'b1;
        nextCycle();
        checkOutput("in-reset m_valid", 101, 32'(mValid), 32'd0);
        checkOutput("in-reset busy",    101, 32'(busy),   32'd0);
        nextCycle();
        rst = 1'b0;
        #3;
        checkOutput("post-reset m_valid", 102, 32'(mValid), 32'd0);
        checkOutput("post-reset busy",    102, 32'(busy),    32'd0);
        checkOutput("post-reset s_ready", 102, 32'(sReady),  32'd0);
        checkOutput("post-reset dp_ar",   102, 32'(dpAr),    32'd0);
        checkOutput("post-reset dp_ag",   102, 32'(dpAg),    32'd0);
        for (int i = 0; i < 6; i++) begin
            nextCycle();
            #3;
            checkOutput("dropped m_valid",    103 + i, 32'(mValid),    32'd0);
            checkOutput("dropped frame_done", 103 + i, 32'(frameDone), 32'd0);
            checkOutput("dropped dp_tinv",    103 + i, 32'(dpTinv),    32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
